// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - external memory bus controller arbitrating PC fetch and ALU load/store
// Optional transfer watchdog enabled by defining MEM_WATCHDOG_EN.
module mem_bus_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_fetch_req,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [1:0]        mem_op,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    output logic              ext_wdata_en,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic [2:0]        ext_drive,
    input  logic              ext_ready,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DREAD,
        S_DWRITE
    } state_t;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_FETCH = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;

    state_t              state_q, state_d;
    logic                fetch_pend_q, fetch_pend_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic                data_pend_q, data_pend_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]   dwdata_q, dwdata_d;
    logic [DATA_W-1:0]   instr_out_q, instr_out_d;
    logic                instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_done_q, wr_done_d;
    logic [ADDR_W-1:0]   ext_addr_q, ext_addr_d;
    logic [DATA_W-1:0]   ext_wdata_q, ext_wdata_d;
    logic                ext_wdata_en_q, ext_wdata_en_d;
    logic [2:0]          ext_drive_q, ext_drive_d;
    logic                end_xfer;

`ifdef MEM_WATCHDOG_EN
    localparam int WD_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 32) ? 32 : WD_RAW);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d        = state_q;
        fetch_pend_d   = fetch_pend_q;
        fetch_addr_d   = fetch_addr_q;
        data_pend_d    = data_pend_q;
        op_d           = op_q;
        daddr_d        = daddr_q;
        dwdata_d       = dwdata_q;
        instr_out_d    = instr_out_q;
        instr_valid_d  = 1'b0;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        wr_done_d      = 1'b0;
        ext_addr_d     = ext_addr_q;
        ext_wdata_d    = ext_wdata_q;
        ext_wdata_en_d = ext_wdata_en_q;
        ext_drive_d    = ext_drive_q;
        end_xfer       = 1'b0;
`ifdef MEM_WATCHDOG_EN
        wd_cnt_d       = '0;
        bus_err_d      = bus_err_q;
`endif

        // One outstanding request per port; pending flags stay set until the transfer ends.
        if (pc_fetch_req && !fetch_pend_q) begin
            fetch_pend_d = 1'b1;
            fetch_addr_d = pc_addr;
        end
        if ((mem_op == OP_READ || mem_op == OP_WRITE) && !data_pend_q) begin
            data_pend_d = 1'b1;
            op_d        = mem_op;
            daddr_d     = alu_addr;
            dwdata_d    = wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (data_pend_q) begin
                    ext_addr_d = daddr_q;
                    if (op_q == OP_WRITE) begin
                        state_d        = S_DWRITE;
                        ext_drive_d    = CMD_WRITE;
                        ext_wdata_d    = dwdata_q;
                        ext_wdata_en_d = 1'b1;
                    end else begin
                        state_d     = S_DREAD;
                        ext_drive_d = CMD_READ;
                    end
                end else if (fetch_pend_q) begin
                    state_d     = S_FETCH;
                    ext_drive_d = CMD_FETCH;
                    ext_addr_d  = fetch_addr_q;
                end
            end
            default: begin
                if (ext_ready) begin
                    end_xfer = 1'b1;
                    case (state_q)
                        S_FETCH: begin
                            instr_out_d   = ext_rdata;
                            instr_valid_d = 1'b1;
                        end
                        S_DREAD: begin
                            rd_data_d  = ext_rdata;
                            rd_valid_d = 1'b1;
                        end
                        default: wr_done_d = 1'b1;
                    endcase
                end
`ifdef MEM_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    end_xfer  = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
        endcase

        // Completion and watchdog abort release the bus the same way.
        if (end_xfer) begin
            state_d        = S_IDLE;
            ext_drive_d    = CMD_IDLE;
            ext_wdata_en_d = 1'b0;
            if (state_q == S_FETCH) begin
                fetch_pend_d = 1'b0;
            end else begin
                data_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            fetch_pend_q   <= 1'b0;
            fetch_addr_q   <= '0;
            data_pend_q    <= 1'b0;
            op_q           <= 2'b00;
            daddr_q        <= '0;
            dwdata_q       <= '0;
            instr_out_q    <= '0;
            instr_valid_q  <= 1'b0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            wr_done_q      <= 1'b0;
            ext_addr_q     <= '0;
            ext_wdata_q    <= '0;
            ext_wdata_en_q <= 1'b0;
            ext_drive_q    <= CMD_IDLE;
        end else begin
            state_q        <= state_d;
            fetch_pend_q   <= fetch_pend_d;
            fetch_addr_q   <= fetch_addr_d;
            data_pend_q    <= data_pend_d;
            op_q           <= op_d;
            daddr_q        <= daddr_d;
            dwdata_q       <= dwdata_d;
            instr_out_q    <= instr_out_d;
            instr_valid_q  <= instr_valid_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            wr_done_q      <= wr_done_d;
            ext_addr_q     <= ext_addr_d;
            ext_wdata_q    <= ext_wdata_d;
            ext_wdata_en_q <= ext_wdata_en_d;
            ext_drive_q    <= ext_drive_d;
        end
    end

`ifdef MEM_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign instr_out    = instr_out_q;
    assign instr_valid  = instr_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign wr_done      = wr_done_q;
    assign ext_addr     = ext_addr_q;
    assign ext_wdata    = ext_wdata_q;
    assign ext_wdata_en = ext_wdata_en_q;
    assign ext_drive    = ext_drive_q;
    assign busy         = fetch_pend_q | data_pend_q | (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

`ifdef MEM_WATCHDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        pc_fetch_req = 1'b0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] alu_addr = '0;
    logic [1:0]  mem_op = 2'b00;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_done;
    logic        busy;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_wdata_en;
    logic [31:0] ext_rdata = '0;
    logic [2:0]  ext_drive;
    logic        ext_ready = 1'b0;
    logic        bus_err;

    int total = 0;
    int bad = 0;
    int n_ival = 0;
    int n_rval = 0;
    int n_wdone = 0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_rd = '0;

    mem_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_addr(pc_addr), .pc_fetch_req(pc_fetch_req),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .alu_addr(alu_addr), .mem_op(mem_op), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_done(wr_done),
        .busy(busy), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_wdata_en(ext_wdata_en), .ext_rdata(ext_rdata),
        .ext_drive(ext_drive), .ext_ready(ext_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (instr_valid) n_ival++;
        if (rd_valid) n_rval++;
        if (wr_done) n_wdone++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Plays the memory side of one transfer: expects cmd/addr, holds ready low for waits cycles.
    task automatic serve(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] wdat,
                         input int waits, input logic [31:0] rdat, input logic busy_after);
        int n;
        logic [2:0] pulses;
        n = 0;
        while (ext_drive == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (ext_drive !== cmd) begin
            bad++;
            $display("FAIL serve_cmd got=%0h exp=%0h", ext_drive, cmd);
        end
        total++;
        if (ext_addr !== addr) begin
            bad++;
            $display("FAIL serve_addr got=%0h exp=%0h", ext_addr, addr);
        end
        total++;
        if (ext_wdata_en !== (cmd == 3'b011) || busy !== 1'b1) begin
            bad++;
            $display("FAIL serve_en_busy got=%0b%0b exp=%0b1", ext_wdata_en, busy, cmd == 3'b011);
        end
        if (cmd == 3'b011) begin
            total++;
            if (ext_wdata !== wdat) begin
                bad++;
                $display("FAIL serve_wdata got=%0h exp=%0h", ext_wdata, wdat);
            end
        end
        ext_rdata = rdat;
        for (int i = 0; i < waits; i++) begin
            tick();
            total++;
            if (ext_drive !== cmd || ext_addr !== addr || ext_wdata_en !== (cmd == 3'b011)) begin
                bad++;
                $display("FAIL serve_hold cyc=%0d drive=%0h addr=%0h exp=%0h/%0h", i, ext_drive, ext_addr, cmd, addr);
            end
        end
        ext_ready = 1'b1;
        tick();
        ext_ready = 1'b0;
        if (cmd == 3'b001) m_instr = rdat;
        if (cmd == 3'b010) m_rd = rdat;
        pulses = {cmd == 3'b001, cmd == 3'b010, cmd == 3'b011};
        total++;
        if ({instr_valid, rd_valid, wr_done} !== pulses) begin
            bad++;
            $display("FAIL serve_pulse got=%0b exp=%0b", {instr_valid, rd_valid, wr_done}, pulses);
        end
        total++;
        if (instr_out !== m_instr || rd_data !== m_rd) begin
            bad++;
            $display("FAIL serve_data instr=%0h rd=%0h exp=%0h/%0h", instr_out, rd_data, m_instr, m_rd);
        end
        total++;
        if (ext_drive !== 3'b000 || ext_wdata_en !== 1'b0 || busy !== busy_after) begin
            bad++;
            $display("FAIL serve_release drive=%0h en=%0b busy=%0b exp busy=%0b", ext_drive, ext_wdata_en, busy, busy_after);
        end
        tick();
        total++;
        if ({instr_valid, rd_valid, wr_done} !== 3'b000) begin
            bad++;
            $display("FAIL serve_pulse_width got=%0b exp=000", {instr_valid, rd_valid, wr_done});
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({instr_out, instr_valid, rd_data, rd_valid, wr_done, busy, ext_addr, ext_wdata,
             ext_wdata_en, ext_drive, bus_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs busy=%0b drive=%0h addr=%0h exp=all zero", busy, ext_drive, ext_addr);
        end
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || ext_drive !== 3'b000) begin
            bad++;
            $display("FAIL reset_release busy=%0b drive=%0h exp=0/0", busy, ext_drive);
        end
    endtask

    task automatic test_fetch();
        pc_addr = 32'h100;
        pc_fetch_req = 1'b1;
        ext_ready = 1'b1;
        ext_rdata = 32'hDEADBEEF;
        tick();
        pc_fetch_req = 1'b0;
        total++;
        if (ext_drive !== 3'b000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fetch_c1 drive=%0h busy=%0b exp=0/1", ext_drive, busy);
        end
        tick();
        total++;
        if (ext_drive !== 3'b001 || ext_addr !== 32'h100 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_c2 drive=%0h addr=%0h iv=%0b exp=1/100/0", ext_drive, ext_addr, instr_valid);
        end
        tick();
        m_instr = 32'hDEADBEEF;
        total++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fetch_c3 iv=%0b instr=%0h exp=1/deadbeef", instr_valid, instr_out);
        end
        tick();
        ext_ready = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || ext_drive !== 3'b000 || instr_out !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fetch_c4 iv=%0b drive=%0h instr=%0h exp=0/0/deadbeef", instr_valid, ext_drive, instr_out);
        end
    endtask

    task automatic test_store();
        int w0;
        w0 = n_wdone;
        mem_op = 2'b10;
        alu_addr = 32'h2000;
        wr_data = 32'h12345678;
        tick();
        mem_op = 2'b00;
        serve(3'b011, 32'h2000, 32'h12345678, 3, 32'h0, 1'b0);
        tick();
        total++;
        if (n_wdone - w0 !== 1) begin
            bad++;
            $display("FAIL store_done_count got=%0d exp=1", n_wdone - w0);
        end
    endtask

    task automatic test_simultaneous();
        pc_addr = 32'h400;
        pc_fetch_req = 1'b1;
        alu_addr = 32'h3000;
        mem_op = 2'b01;
        tick();
        pc_fetch_req = 1'b0;
        mem_op = 2'b00;
        serve(3'b010, 32'h3000, 32'h0, 1, 32'hA5A5_0001, 1'b1);
        serve(3'b001, 32'h400, 32'h0, 0, 32'h1234_ABCD, 1'b0);
    endtask

    task automatic test_duplicate();
        int r0;
        r0 = n_rval;
        mem_op = 2'b01;
        alu_addr = 32'h5000;
        tick();
        alu_addr = 32'h6000;
        tick();
        mem_op = 2'b11;
        alu_addr = 32'h7000;
        tick();
        mem_op = 2'b00;
        serve(3'b010, 32'h5000, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (n_rval - r0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dup_reads got=%0d busy=%0b exp=1/0", n_rval - r0, busy);
        end
        mem_op = 2'b11;
        tick();
        mem_op = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (busy !== 1'b0 || ext_drive !== 3'b000) begin
            bad++;
            $display("FAIL reserved_op busy=%0b drive=%0h exp=0/0", busy, ext_drive);
        end
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] fa, da, wd, r1, r2;
        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 4);
            fa = $urandom;
            da = $urandom;
            wd = $urandom;
            r1 = $urandom;
            r2 = $urandom;
            pc_addr = fa;
            alu_addr = da;
            wr_data = wd;
            pc_fetch_req = (kind == 0 || kind >= 3);
            mem_op = (kind == 1 || kind == 3) ? 2'b01 : ((kind == 2 || kind == 4) ? 2'b10 : 2'b00);
            tick();
            pc_fetch_req = 1'b0;
            mem_op = 2'b00;
            pc_addr = $urandom;
            alu_addr = $urandom;
            wr_data = $urandom;
            if (kind == 1 || kind == 3) serve(3'b010, da, wd, $urandom_range(0, 3), r1, kind >= 3);
            if (kind == 2 || kind == 4) serve(3'b011, da, wd, $urandom_range(0, 3), r1, kind >= 3);
            if (kind == 0 || kind >= 3) serve(3'b001, fa, wd, $urandom_range(0, 3), r2, 1'b0);
        end
        total++;
        if (bus_err !== 1'b0) begin
            bad++;
            $display("FAIL random_bus_err got=%0b exp=0", bus_err);
        end
    endtask

    task automatic test_reset_mid();
        int n, r0;
        mem_op = 2'b01;
        alu_addr = 32'h8000;
        tick();
        mem_op = 2'b00;
        n = 0;
        while (ext_drive !== 3'b010 && n < 20) begin
            tick();
            n++;
        end
        tick();
        r0 = n_rval;
        ext_rdata = 32'hFFFF_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({instr_out, instr_valid, rd_data, rd_valid, wr_done, busy, ext_addr, ext_wdata,
             ext_wdata_en, ext_drive, bus_err} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs busy=%0b drive=%0h rd=%0h exp=all zero", busy, ext_drive, rd_data);
        end
        m_instr = '0;
        m_rd = '0;
        tick();
        ext_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ext_ready = 1'b0;
        total++;
        if (n_rval !== r0 || busy !== 1'b0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL midreset_no_valid rv=%0d busy=%0b rd=%0h exp=%0d/0/0", n_rval, busy, rd_data, r0);
        end
    endtask

`ifdef MEM_WATCHDOG_EN
    task automatic test_watchdog();
        int n, i0;
        i0 = n_ival;
        pc_addr = 32'h900;
        pc_fetch_req = 1'b1;
        tick();
        pc_fetch_req = 1'b0;
        n = 0;
        while (ext_drive == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (ext_drive == 3'b001 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL wd_cycles got=%0d exp=%0d", n, TO);
        end
        tick();
        total++;
        if (bus_err !== 1'b1 || n_ival !== i0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wd_abort err=%0b iv=%0d busy=%0b exp=1/%0d/0", bus_err, n_ival, busy, i0);
        end
        pc_addr = 32'hA00;
        pc_fetch_req = 1'b1;
        tick();
        pc_fetch_req = 1'b0;
        serve(3'b001, 32'hA00, 32'h0, 2, 32'h5555_AAAA, 1'b0);
        total++;
        if (bus_err !== 1'b1) begin
            bad++;
            $display("FAIL wd_sticky got=%0b exp=1", bus_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_duplicate();
        test_random();
        test_reset_mid();
`ifdef MEM_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Parametrised external-memory bus controller for the APCPU core. Arbitrates between the PC instruction-fetch port and the ALU load/store port for a single external memory bus, drives address/data/command with a ready handshake, and returns fetched instructions and load data with one-cycle valid pulses. Uses separate in/out bus directions instead of tristates; top-level pads merge them.

Parameters:
DATA_W, 32, width of data and instruction words
ADDR_W, 32, width of all address buses
TIMEOUT_CYC, 255, watchdog limit in cycles waiting for ext_ready (used only with MEM_WATCHDOG_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pc_addr  in  ADDR_W  fetch address from PC
pc_fetch_req  in  1  one-cycle pulse: fetch instruction at pc_addr
instr_out  out  DATA_W  last fetched instruction, held until next fetch completes
instr_valid  out  1  one-cycle pulse when instr_out updates
alu_addr  in  ADDR_W  load/store address
mem_op  in  2  00 NOP, 01 read, 10 write, 11 reserved (ignored)
wr_data  in  DATA_W  store data
rd_data  out  DATA_W  load result, held until next load completes
rd_valid  out  1  one-cycle pulse when rd_data updates
wr_done  out  1  one-cycle pulse when a store completes
busy  out  1  high while any request is pending or in flight
ext_addr  out  ADDR_W  external address bus
ext_wdata  out  DATA_W  external write data
ext_wdata_en  out  1  pad enable for ext_wdata (high only during write)
ext_rdata  in  DATA_W  external read data
ext_drive  out  3  command: 000 idle, 001 fetch, 010 mem read, 011 mem write, 1xx never driven
ext_ready  in  1  external side completes current transfer this cycle
bus_err  out  1  sticky watchdog error (tied 0 without MEM_WATCHDOG_EN)

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0, incl. instr_out, rd_data, ext_addr, ext_wdata; pending flags cleared. In-flight transfer abandoned, no valid/done pulse.
- Request capture: pc_fetch_req sets fetch_pend; mem_op 01/10 sets data_pend and latches op, alu_addr, wr_data. Captured in any state. New data request while data_pend or data transfer in flight: ignored (one outstanding). Same for fetch. mem_op 11 ignored.
- FSM states: IDLE, FETCH, DREAD, DWRITE.
- IDLE: if data_pend -> DREAD/DWRITE, else if fetch_pend -> FETCH. Data has priority over fetch. Request captured in cycle N, pending checked in cycle N+1; ext_drive/ext_addr valid from cycle N+2 edge. Minimum request-to-valid latency 3 cycles with ext_ready already high.
- FETCH/DREAD/DWRITE: ext_drive, ext_addr (and ext_wdata, ext_wdata_en=1 for write) held stable until ext_ready sampled high. On that edge: FETCH loads instr_out <= ext_rdata, instr_valid=1 next cycle; DREAD loads rd_data, rd_valid=1; DWRITE wr_done=1; pending flag cleared; ext_drive <= 000, ext_wdata_en <= 0; return to IDLE (one idle cycle between transfers minimum).
- ext_ready while in IDLE: ignored.
- Valid/done pulses exactly one cycle wide.
- busy = fetch_pend | data_pend | (state != IDLE).
- Widths: no arithmetic; buses passed through unmodified at DATA_W/ADDR_W.

Optional Feature:
MEM_WATCHDOG_EN: when defined, an 8..32-bit counter (width clog2(TIMEOUT_CYC+1)) counts cycles in FETCH/DREAD/DWRITE without ext_ready; on reaching TIMEOUT_CYC the transfer aborts: ext_drive <= 000, pending flag cleared, no valid/done pulse, bus_err set sticky until reset, return to IDLE. Counter clears on each state entry. Without macro: controller waits indefinitely, bus_err constant 0, no counter logic.

Test Plan:
- Reset mid-transfer: assert rst_n=0 in DREAD with ext_ready=0 -> all outputs 0 immediately, no rd_valid after release.
- Fetch: pc_addr=0x100, pc_fetch_req pulse, ext_ready=1, ext_rdata=0xDEADBEEF -> ext_drive=001 with ext_addr=0x100, instr_out=0xDEADBEEF with 1-cycle instr_valid 3 cycles after request.
- Store with wait states: mem_op=10, alu_addr=0x2000, wr_data=0x12345678, ext_ready high after 4 cycles -> ext_drive=011, ext_wdata_en=1 held 4 cycles, single wr_done pulse, ext_drive back to 000.
- Simultaneous requests: pc_fetch_req and mem_op=01 same cycle -> DREAD served first, rd_valid, then FETCH, instr_valid; busy high throughout.
- Duplicate/reserved: mem_op=01 twice while read pending, then mem_op=11 -> exactly one read transfer, one rd_valid.
- Watchdog (MEM_WATCHDOG_EN, TIMEOUT_CYC=8): fetch with ext_ready held 0 -> abort after 8 cycles, bus_err=1 sticky, no instr_valid, next request served normally.
